// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one synchronous FIFO write port among NREQ producers. Grants a
//   single producer at a time for bursts of up to MAX_BURST beats, then
//   re-arbitrates round-robin. The FIFO writes memory on any wr_en even when
//   full, so every beat is gated by fifo_full here.
//
//   Optional build macro: ARB_PRIO0_EN
//     defined   -> req 0 wins every arbitration it takes part in; the others
//                  share round-robin among themselves (starvation accepted)
//     undefined -> pure round-robin over all requesters
//
// Ports
//   clk        in   1        clock, rising edge
//   rstn       in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester beat valid
//   req_data   in   NREQ*DW  requester i data at [i*DW +: DW]
//   req_ready  out  NREQ     per-requester beat accept (grant && !fifo_full)
//   fifo_full  in   1        FIFO full flag
//   fifo_wr_en out  1        FIFO write enable
//   fifo_din   out  DW       FIFO write data (0 when nothing granted)
//   grant      out  NREQ     registered one-hot owner, 0 = none
//   busy       out  1        |grant
//
// FSM states
//   state   | meaning
//   S_IDLE  | no owner; waiting for any req_valid
//   S_GRANT | one owner holds the write port for the current burst

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_din,
    output logic [NREQ-1:0]    grant,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_owner_q, last_owner_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NREQ-1:0]   xfer;
    logic              owner_valid;
    logic              transfer;
    logic              last_beat;
    logic [NREQ-1:0]   arb_mask;
    logic [IW-1:0]     arb_last;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    // Returns {found, index}. Search starts at last+1 and wraps.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   last);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
`ifdef ARB_PRIO0_EN
        if (mask[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IW'((int'(last) + k) % NREQ);
                if (!found && (cand != '0) && mask[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
`endif
        return {found, idx};
    endfunction

    // Datapath: combinational so a beat lands in the FIFO on its transfer edge.
    assign req_ready   = grant_q & {NREQ{~fifo_full}};
    assign xfer        = req_valid & req_ready;
    assign fifo_wr_en  = |xfer;
    assign grant       = grant_q;
    assign busy        = |grant_q;
    assign owner_valid = |(req_valid & grant_q);
    assign transfer    = |xfer;
    assign last_beat   = (beat_cnt_q == BW'(MAX_BURST - 1));

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) fifo_din = fifo_din | req_data[i*DW +: DW];
        end
    end

    // A released owner that dropped valid is masked out so it cannot win the
    // same-cycle re-arbitration; a burst-limit release leaves it eligible.
    always_comb begin
        arb_mask = req_valid;
        arb_last = last_owner_q;
        if (state_q == S_GRANT) begin
            arb_last = owner_q;
            if (!owner_valid) arb_mask = req_valid & ~grant_q;
        end
        {pick_found, pick_idx} = rr_pick(arb_mask, arb_last);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_GRANT;
                    grant_d    = NREQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if ((transfer && last_beat) || !owner_valid) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    if (pick_found) begin
                        grant_d = NREQ'(1) << pick_idx;
                        owner_d = pick_idx;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else if (transfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic               clk;
    logic               rstn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_din;
    logic [NREQ-1:0]    grant;
    logic               busy;

    int vec;
    int err;

    // Producer model: rem = beats left to offer, seq = next data index,
    // cnt = beats accepted since the last reset.
    int rem [NREQ];
    int seq [NREQ];
    int cnt [NREQ];

    // Values sampled mid-cycle, before the edge that follows.
    logic [NREQ-1:0] o_grant;
    logic [NREQ-1:0] o_rdy;
    logic            o_we;
    logic [DW-1:0]   o_din;
    logic            o_busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = (rem[i] > 0);
            req_data[i*DW +: DW]    = 8'(i * 32 + seq[i]);
        end
    endtask

    task automatic step();
        apply();
        #1;
        o_grant = grant;
        o_rdy   = req_ready;
        o_we    = fifo_wr_en;
        o_din   = fifo_din;
        o_busy  = busy;
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && o_rdy[i]) begin
                rem[i] = rem[i] - 1;
                seq[i] = seq[i] + 1;
                cnt[i] = cnt[i] + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
            cnt[i] = 0;
        end
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 1;
            seq[i] = 5;
        end
        apply();
        @(posedge clk);
        #1;
        vec++; if (grant !== 4'b0000) begin err++; $display("FAIL reset_grant: got %b, required 0000", grant); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vec++; if (req_ready !== 4'b0000) begin err++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        vec++; if (fifo_wr_en !== 1'b0) begin err++; $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); end
        vec++; if (fifo_din !== 8'h00) begin err++; $display("FAIL reset_din: got %h, required 00", fifo_din); end
        do_reset();
    endtask

    // Single producer, 6 beats: bursts of 4 then 2, re-granted with no gap.
    task automatic test_single_req();
        do_reset();
        rem[1] = 6;
        step();
        vec++; if (o_grant !== 4'b0000) begin err++; $display("FAIL single_first_grant: got %b, required 0000", o_grant); end
        vec++; if (o_din !== 8'h00) begin err++; $display("FAIL single_din_idle: got %h, required 00", o_din); end
        for (int j = 0; j < 6; j++) begin
            step();
            vec++; if (o_grant !== 4'b0010) begin err++; $display("FAIL single_grant beat %0d: got %b, required 0010", j, o_grant); end
            vec++; if (o_we !== 1'b1) begin err++; $display("FAIL single_wr_en beat %0d: got %b, required 1", j, o_we); end
            vec++; if (o_din !== 8'(32 + j)) begin err++; $display("FAIL single_din beat %0d: got %h, required %h", j, o_din, 8'(32 + j)); end
        end
        step();
        vec++; if (o_we !== 1'b0) begin err++; $display("FAIL single_tail_wr_en: got %b, required 0", o_we); end
        step();
        vec++; if (o_grant !== 4'b0000) begin err++; $display("FAIL single_release: got %b, required 0000", o_grant); end
        vec++; if (cnt[1] !== 6) begin err++; $display("FAIL single_count: got %0d, required 6", cnt[1]); end
    endtask

    // All four continuously valid: 0,1,2,3,0 with 4 beats each.
    task automatic test_round_robin();
        int own;
        logic [NREQ-1:0] eg;
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        step();
        vec++; if (o_we !== 1'b0) begin err++; $display("FAIL rr_first_wr_en: got %b, required 0", o_we); end
        for (int j = 0; j < 20; j++) begin
            step();
            own = (j / 4) % 4;
            eg  = 4'(1 << own);
            vec++; if (o_grant !== eg) begin err++; $display("FAIL rr_grant cycle %0d: got %b, required %b", j, o_grant, eg); end
            vec++; if (o_we !== 1'b1) begin err++; $display("FAIL rr_wr_en cycle %0d: got %b, required 1", j, o_we); end
            vec++; if (o_din !== 8'(own * 32 + (j / 16) * 4 + j % 4)) begin err++; $display("FAIL rr_din cycle %0d: got %h, required %h", j, o_din, 8'(own * 32 + (j / 16) * 4 + j % 4)); end
            if (j == 15) begin
                for (int i = 0; i < NREQ; i++) begin
                    vec++; if (cnt[i] !== 4) begin err++; $display("FAIL rr_burst_len req %0d: got %0d, required 4", i, cnt[i]); end
                end
            end
        end
    endtask

    // FIFO full for 3 cycles after 2 beats; burst resumes and finishes.
    task automatic test_fifo_full();
        do_reset();
        rem[2] = 4;
        step();
        step();
        vec++; if (o_din !== 8'd64) begin err++; $display("FAIL full_beat0: got %h, required 40", o_din); end
        step();
        fifo_full = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            vec++; if (o_we !== 1'b0) begin err++; $display("FAIL full_wr_en stall %0d: got %b, required 0", j, o_we); end
            vec++; if (o_rdy !== 4'b0000) begin err++; $display("FAIL full_ready stall %0d: got %b, required 0000", j, o_rdy); end
            vec++; if (o_grant !== 4'b0100) begin err++; $display("FAIL full_grant stall %0d: got %b, required 0100", j, o_grant); end
        end
        fifo_full = 1'b0;
        for (int j = 2; j < 4; j++) begin
            step();
            vec++; if (o_we !== 1'b1) begin err++; $display("FAIL full_resume_wr_en beat %0d: got %b, required 1", j, o_we); end
            vec++; if (o_din !== 8'(64 + j)) begin err++; $display("FAIL full_resume_din beat %0d: got %h, required %h", j, o_din, 8'(64 + j)); end
        end
        // Burst limit hit with owner still valid on that edge -> re-granted,
        // then released on its dropped valid.
        step();
        vec++; if (o_grant !== 4'b0100) begin err++; $display("FAIL full_regrant: got %b, required 0100", o_grant); end
        step();
        vec++; if (o_grant !== 4'b0000) begin err++; $display("FAIL full_idle: got %b, required 0000", o_grant); end
        vec++; if (cnt[2] !== 4) begin err++; $display("FAIL full_count: got %0d, required 4", cnt[2]); end
    endtask

    // Owner drops valid early; next requester takes over the following cycle.
    task automatic test_owner_drop();
        do_reset();
        rem[2] = 2;
        rem[3] = 1000;
        step();
        step();
        vec++; if (o_grant !== 4'b0100) begin err++; $display("FAIL drop_first_owner: got %b, required 0100", o_grant); end
        step();
        step();
        vec++; if (o_we !== 1'b0) begin err++; $display("FAIL drop_gap_wr_en: got %b, required 0", o_we); end
        step();
        vec++; if (o_grant !== 4'b1000) begin err++; $display("FAIL drop_handover: got %b, required 1000", o_grant); end
        vec++; if (o_din !== 8'd96) begin err++; $display("FAIL drop_handover_din: got %h, required 60", o_din); end
        vec++; if (cnt[2] !== 2) begin err++; $display("FAIL drop_count: got %0d, required 2", cnt[2]); end
    endtask

    // Async reset mid-burst of req1; afterwards req0 is served first again.
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        repeat (6) step();
        vec++; if (o_grant !== 4'b0010) begin err++; $display("FAIL areset_setup: got %b, required 0010", o_grant); end
        #2;
        rstn = 1'b0;
        #1;
        vec++; if (grant !== 4'b0000) begin err++; $display("FAIL areset_grant: got %b, required 0000", grant); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL areset_busy: got %b, required 0", busy); end
        vec++; if (fifo_wr_en !== 1'b0) begin err++; $display("FAIL areset_wr_en: got %b, required 0", fifo_wr_en); end
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        step();
        for (int j = 0; j < 4; j++) begin
            step();
            vec++; if (o_grant !== 4'b0001) begin err++; $display("FAIL areset_req0 cycle %0d: got %b, required 0001", j, o_grant); end
        end
        step();
        vec++; if (o_grant !== 4'b0010) begin err++; $display("FAIL areset_next: got %b, required 0010", o_grant); end
    endtask

    // req0 and req2 continuously valid.
    task automatic test_prio0();
        logic [NREQ-1:0] eg;
        do_reset();
        rem[0] = 1000;
        rem[2] = 1000;
        step();
        for (int j = 0; j < 12; j++) begin
            step();
`ifdef ARB_PRIO0_EN
            eg = 4'b0001;
`else
            eg = (((j / 4) % 2) == 1) ? 4'b0100 : 4'b0001;
`endif
            vec++; if (o_grant !== eg) begin err++; $display("FAIL prio_grant cycle %0d: got %b, required %b", j, o_grant, eg); end
        end
`ifdef ARB_PRIO0_EN
        vec++; if (cnt[2] !== 0) begin err++; $display("FAIL prio_starve: got %0d, required 0", cnt[2]); end
`else
        vec++; if (cnt[2] !== 4) begin err++; $display("FAIL prio_share: got %0d, required 4", cnt[2]); end
`endif
    endtask

    initial begin
        vec       = 0;
        err       = 0;
        rstn      = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_single_req();
        test_round_robin();
        test_fifo_full();
        test_owner_drop();
        test_async_reset();
        test_prio0();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
